// File: rtl/avalon_dual_port_ram.sv
// True-dual-port scratch RAM with two Avalon-MM slave ports, pipelined reads,
// a hardware clear sequencer and a sticky same-address write-collision flag.
module avalon_dual_port_ram #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    DEPTH          = 8192,
  parameter int                    READ_LATENCY   = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  localparam int                   ADDR_WIDTH     = $clog2(DEPTH),
  localparam int                   BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  init_done,
  output logic                  collision,
  input  logic [ADDR_WIDTH-1:0] s1_address,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [BE_WIDTH-1:0]   s1_byteenable,
  input  logic [DATA_WIDTH-1:0] s1_writedata,
  output logic                  s1_waitrequest,
  output logic [DATA_WIDTH-1:0] s1_readdata,
  output logic                  s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] s2_address,
  input  logic                  s2_read,
  input  logic                  s2_write,
  input  logic [BE_WIDTH-1:0]   s2_byteenable,
  input  logic [DATA_WIDTH-1:0] s2_writedata,
  output logic                  s2_waitrequest,
  output logic [DATA_WIDTH-1:0] s2_readdata,
  output logic                  s2_readdatavalid
);

  // ST_BOOT only exists so waitrequest stays high through reset when no clear runs.
  typedef enum logic [1:0] {ST_BOOT, ST_CLEAR, ST_READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  collision_q, collision_d;

  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [BE_WIDTH-1:0]   be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic [1:0]            rvalid;
  logic [1:0]            rd_acc, wr_acc;
  logic                  ready;

  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;

  assign ready  = (state_q == ST_READY);
  assign wr_acc = {s2_write, s1_write} & {2{ready}};
  assign rd_acc = {s2_read & ~s2_write, s1_read & ~s1_write} & {2{ready}};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    collision_d = collision_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_READY;
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_READY;
      end
      ST_READY: begin
        if (clear_req) begin
          state_d     = ST_CLEAR;
          clr_cnt_d   = '0;
          collision_d = 1'b0;
        end else if (wr_acc == 2'b11 && addr[0] == addr[1]) begin
          collision_d = 1'b1;
        end
      end
      default:  state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
      else                state_q <= ST_BOOT;
      clr_cnt_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      collision_q <= collision_d;
    end
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; clearing it is the sequencer's job, one word per cycle.
  // s1 is written last so it owns any byte lane both ports enable on the same word.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) mem_q[clr_cnt_q] <= CLEAR_VALUE;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (wr_acc[1] && be[1][b]) mem_q[addr[1]][b*8 +: 8] <= wdata[1][b*8 +: 8];
      if (wr_acc[0] && be[0][b]) mem_q[addr[0]][b*8 +: 8] <= wdata[0][b*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] d0_q;
    logic                  v0_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v0_q <= 1'b0;
        d0_q <= '0;
      end else begin
        v0_q <= rd_acc[p];
        if (rd_acc[p]) d0_q <= mem_q[addr[p]];
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] d1_q;
      logic                  v1_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v1_q <= 1'b0;
          d1_q <= '0;
        end else begin
          v1_q <= v0_q;
          if (v0_q) d1_q <= d0_q;
        end
      end

      assign rvalid[p] = v1_q;
      assign rdata[p]  = d1_q;
    end else begin : g_lat1
      assign rvalid[p] = v0_q;
      assign rdata[p]  = d0_q;
    end
  end

  assign init_done        = ready;
  assign collision        = collision_q;
  assign s1_waitrequest   = ~ready;
  assign s2_waitrequest   = ~ready;
  assign s1_readdata      = rdata[0];
  assign s2_readdata      = rdata[1];
  assign s1_readdatavalid = rvalid[0];
  assign s2_readdatavalid = rvalid[1];

endmodule

// File: doc/avalon_dual_port_ram.md
Name: avalon_dual_port_ram

Overview:
- Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2) on one clock domain.
- Next-generation local memory for Nios II subsystems. Adds configurable width, depth and read latency.
- Adds pipelined reads (readdatavalid), waitrequest back-pressure, a hardware clear sequencer and write-collision detection.
- Sits between the system interconnect and processor/DMA masters sharing a scratch buffer.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8, range 8..128.
- DEPTH, 8192, number of words; power of two, range 16..65536.
- ADDR_WIDTH, clog2(DEPTH), word-address width; derived, never overridden.
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, when 1 the memory is filled with CLEAR_VALUE after every reset release.
- CLEAR_VALUE, 0, DATA_WIDTH-bit fill pattern.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- clear_req  in  1  one-cycle pulse; requests a full memory clear.
- init_done  out  1  high when in READY state.
- collision  out  1  sticky flag: set on a same-address same-cycle write from both ports.
- s1_address, s2_address  in  ADDR_WIDTH  word address.
- s1_read, s2_read  in  1  read request.
- s1_write, s2_write  in  1  write request.
- s1_byteenable, s2_byteenable  in  DATA_WIDTH/8  byte lane enables.
- s1_writedata, s2_writedata  in  DATA_WIDTH  write data.
- s1_waitrequest, s2_waitrequest  out  1  command not accepted this cycle.
- s1_readdata, s2_readdata  out  DATA_WIDTH  read data.
- s1_readdatavalid, s2_readdatavalid  out  1  readdata valid this cycle.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - waitrequest=1 on both ports; readdatavalid=0; readdata=0.
  - init_done=0; collision=0; clear counter=0; read pipelines flushed.
  - Memory contents are not reset.
- State machine:
  - CLEAR -> READY after the last write.
  - READY -> CLEAR on clear_req.
  - After reset release, enter CLEAR if CLEAR_ON_RESET=1, otherwise enter READY.
- CLEAR state:
  - Writes CLEAR_VALUE to address 0, 1, ... DEPTH-1, one word per cycle; exactly DEPTH cycles.
  - waitrequest=1 on both ports; init_done=0.
  - Enters READY the cycle after address DEPTH-1 is written.
  - Counter wraps to 0 on the next entry.
- READY state: waitrequest=0 on both ports; init_done=1.
- clear_req in READY:
  - Commands presented in the same cycle are still accepted.
  - CLEAR starts the next cycle.
  - In-flight reads complete with pre-clear data.
  - collision is cleared on CLEAR entry.
- clear_req during CLEAR: ignored.
- Reset asserted mid-CLEAR: sequence aborts; it restarts from address 0 after release (when CLEAR_ON_RESET=1).
- Acceptance: a command is accepted when (read|write) & !waitrequest.
- Writes:
  - Memory updates at the accepting edge, per enabled byte lane.
  - byteenable=0 means no change.
- Reads:
  - readdatavalid pulses exactly READ_LATENCY cycles after acceptance, one pulse per accepted read.
  - Back-to-back reads every cycle are supported; responses return in order.
  - readdata holds its last value when readdatavalid=0.
- read and write both asserted on one port in one cycle: the write is performed, the read is dropped, and no readdatavalid is produced.
- Read during write:
  - Same port: returns the old word.
  - Cross-port, same address, same cycle: returns the old word.
- Dual write, same address, same cycle:
  - Byte lanes enabled on both ports take s1 data.
  - Lanes enabled on one port only take that port's data.
  - collision is set the next cycle and stays set until reset or CLEAR entry.
- No other stall sources exist; waitrequest is a pure function of state.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, DEPTH=16, CLEAR_VALUE=0xA5A5A5A5 -> waitrequest high for exactly 16 cycles; init_done rises on cycle 17; a read of every address returns 0xA5A5A5A5.
- s1 writes 0x11223344 to address 5 with byteenable=4'b0101, then reads address 5 (prior contents 0) -> readdatavalid exactly READ_LATENCY cycles later, data 0x00220044. Repeat with READ_LATENCY=2.
- Same cycle: s1 writes 0xAAAAAAAA with be=4'b0011 and s2 writes 0xBBBBBBBB with be=4'b1110, both to address 7 -> word = 0xBBBBAAAA; collision=1 next cycle and held.
- s2 reads address 3 (holding 0x1) while s1 writes 0x2 to address 3 in the same cycle -> s2 returns 0x1; a following read returns 0x2.
- clear_req pulse while 2 reads are in flight (READ_LATENCY=2) -> both return pre-clear data; waitrequest high for DEPTH cycles; collision cleared; all words equal CLEAR_VALUE afterwards.
- reset_n asserted at clear step 8 of 16 -> outputs take reset values immediately; after release the full 16-cycle clear reruns from address 0.
